mtx_tag_hop_ctrl: RTL and testbench

Parametrised frame sequencer for the tag-chip multi-tone TX path, the next generation of the chip-A/B TX controller. It aligns frames to the tag's DCO clock, which is sampled from a front-panel GPIO pin. Each frame has a pilot interval followed by up to `2^BIT_CNT_WIDTH-1` keyed data bits, and the block frequency-hops over a programmable hop table at every bit boundary. Its phase-increment output drives the MTX NCO, and `hop_clk`/`hop_rst` go to the downstream hop logic. Single-shot and continuous modes are supported.

---
 rtl/mtx_tag_hop_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mtx_tag_hop_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_tag_hop_ctrl.sv
// mtx_tag_hop_ctrl
// Frame sequencer for the multi-tone TX path. It aligns each frame to the tag DCO
// (sampled from a GPIO pin) and runs an ALIGN tick, then a pilot interval, then keyed
// data bits. The NCO phase increment hops over a linear hop table at every bit boundary.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   fp_gpio_in             GPIO inputs; bit DCO_BIT carries the asynchronous DCO
//   start, stop            frame start (IDLE only) / abort (any non-IDLE state)
//   cont_mode              restart automatically after each frame
//   tx_bits .. hop_step_inc  frame configuration, latched into shadows at frame start
//   hop_ph_inc, hop_idx    current NCO phase increment and hop index
//   hop_clk, hop_rst       one-cycle pulses: hop advance / frame start
//   tx_bit, ntx_bits_cnt   current data bit and its index
//   mtx_state, busy        FSM state (IDLE=0 ALIGN=1 PILOT=2 DATA=3), busy flag
//   frame_done             one-cycle pulse at frame end
//   fp_gpio_out/_ddr       tx_bit echoed on TX_GPIO_BIT; direction constant
module mtx_tag_hop_ctrl #(
   parameter int unsigned PHASE_WIDTH   = 24,
   parameter int unsigned TX_BITS_WIDTH = 128,
   parameter int unsigned BIT_CNT_WIDTH = 7,
   parameter int unsigned NSYMB_WIDTH   = 16,
   parameter int unsigned HOP_WIDTH     = 4,
   parameter int unsigned REG_WIDTH     = 12,
   parameter int unsigned DCO_BIT       = 1,
   parameter int unsigned TX_GPIO_BIT   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [REG_WIDTH-1:0]     fp_gpio_in,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     cont_mode,
   input  logic [TX_BITS_WIDTH-1:0] tx_bits,
   input  logic [BIT_CNT_WIDTH-1:0] ntx_bits,
   input  logic [NSYMB_WIDTH-1:0]   npilot,
   input  logic [NSYMB_WIDTH-1:0]   edges_per_bit,
   input  logic [HOP_WIDTH-1:0]     nhop,
   input  logic [PHASE_WIDTH-1:0]   hop_base_inc,
   input  logic [PHASE_WIDTH-1:0]   hop_step_inc,
   output logic [PHASE_WIDTH-1:0]   hop_ph_inc,
   output logic [HOP_WIDTH-1:0]     hop_idx,
   output logic                     hop_clk,
   output logic                     hop_rst,
   output logic                     tx_bit,
   output logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
   output logic [1:0]               mtx_state,
   output logic                     busy,
   output logic                     frame_done,
   output logic [REG_WIDTH-1:0]     fp_gpio_out,
   output logic [REG_WIDTH-1:0]     fp_gpio_ddr
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAlign = 2'd1,
      StPilot = 2'd2,
      StData  = 2'd3
   } state_e;

   localparam logic [NSYMB_WIDTH-1:0]   NsOne  = NSYMB_WIDTH'(1);
   localparam logic [BIT_CNT_WIDTH-1:0] BcOne  = BIT_CNT_WIDTH'(1);
   localparam logic [HOP_WIDTH-1:0]     HopOne = HOP_WIDTH'(1);

   // Only the DCO bit of the GPIO bank is used.
   logic gpio_unused;
   assign gpio_unused = ^fp_gpio_in;

   // ---------------------------------------------------------------- DCO tick
   logic [1:0] sync_q;
   logic       lvl_q;
   logic       armed_q;  // set once the synchronised level has been seen low
   logic       tick_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= 2'b00;
         lvl_q   <= 1'b0;
         armed_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], fp_gpio_in[DCO_BIT]};
         lvl_q   <= sync_q[1];
         // A pin held high through reset must go low before it can tick.
         armed_q <= armed_q | ~sync_q[1];
         tick_q  <= sync_q[1] & ~lvl_q & armed_q;
      end
   end

   // ---------------------------------------------------------------- shadows
   state_e                     state_q;
   logic [TX_BITS_WIDTH-1:0]   sh_bits_q;
   logic [BIT_CNT_WIDTH-1:0]   sh_nbits_q;
   logic [NSYMB_WIDTH-1:0]     sh_npilot_q;
   logic [NSYMB_WIDTH-1:0]     sh_epb_q;
   logic [HOP_WIDTH-1:0]       sh_nhop_q;
   logic [PHASE_WIDTH-1:0]     sh_base_q;
   logic [PHASE_WIDTH-1:0]     sh_step_q;

   logic [NSYMB_WIDTH-1:0]     cnt_q;
   logic [PHASE_WIDTH-1:0]     ph_q;
   logic [HOP_WIDTH-1:0]       idx_q;
   logic [BIT_CNT_WIDTH-1:0]   bcnt_q;
   logic                       hop_clk_q, hop_rst_q, tx_bit_q, busy_q, frame_done_q;

   logic                       frame_end;
   logic                       latch;
   logic                       pilot_last;
   logic                       bit_done;
   logic                       last_bit;
   logic [NSYMB_WIDTH-1:0]     epb_eff;
   logic [HOP_WIDTH-1:0]       hop_last;
   logic [BIT_CNT_WIDTH-1:0]   bcnt_next;

   always_comb begin
      epb_eff    = (sh_epb_q == '0) ? NsOne : sh_epb_q;
      hop_last   = (sh_nhop_q == '0) ? '0 : sh_nhop_q - HopOne;
      pilot_last = (cnt_q + NsOne) == sh_npilot_q;
      bit_done   = (cnt_q + NsOne) == epb_eff;
      last_bit   = bcnt_q == (sh_nbits_q - BcOne);
      bcnt_next  = bcnt_q + BcOne;
      frame_end  = 1'b0;
      if (tick_q && !stop) begin
         unique case (state_q)
            StAlign: frame_end = (sh_npilot_q == '0) && (sh_nbits_q == '0);
            StPilot: frame_end = pilot_last && (sh_nbits_q == '0);
            StData:  frame_end = bit_done && last_bit;
            default: frame_end = 1'b0;
         endcase
      end
      latch = ((state_q == StIdle) && start) || (frame_end && cont_mode);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_bits_q   <= '0;
         sh_nbits_q  <= '0;
         sh_npilot_q <= '0;
         sh_epb_q    <= '0;
         sh_nhop_q   <= '0;
         sh_base_q   <= '0;
         sh_step_q   <= '0;
      end else if (latch) begin
         sh_bits_q   <= tx_bits;
         sh_nbits_q  <= ntx_bits;
         sh_npilot_q <= npilot;
         sh_epb_q    <= edges_per_bit;
         sh_nhop_q   <= nhop;
         sh_base_q   <= hop_base_inc;
         sh_step_q   <= hop_step_inc;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         ph_q         <= '0;
         idx_q        <= '0;
         bcnt_q       <= '0;
         hop_clk_q    <= 1'b0;
         hop_rst_q    <= 1'b0;
         tx_bit_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         hop_clk_q    <= 1'b0;
         hop_rst_q    <= 1'b0;
         frame_done_q <= 1'b0;
         if (state_q != StIdle && stop) begin
            // Abort: back to reset values, no frame_done.
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            ph_q     <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            tx_bit_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q <= StAlign;
                     busy_q  <= 1'b1;
                  end
               end
               StAlign: begin
                  if (tick_q) begin
                     hop_rst_q <= 1'b1;
                     idx_q     <= '0;
                     ph_q      <= sh_base_q;
                     cnt_q     <= '0;
                     bcnt_q    <= '0;
                     tx_bit_q  <= 1'b0;
                     if (sh_npilot_q != '0) begin
                        state_q <= StPilot;
                     end else if (sh_nbits_q != '0) begin
                        state_q  <= StData;
                        tx_bit_q <= sh_bits_q[0];
                     end
                  end
               end
               StPilot: begin
                  if (tick_q) begin
                     if (pilot_last) begin
                        cnt_q <= '0;
                        if (sh_nbits_q != '0) begin
                           state_q  <= StData;
                           bcnt_q   <= '0;
                           tx_bit_q <= sh_bits_q[0];
                        end
                     end else begin
                        cnt_q <= cnt_q + NsOne;
                     end
                  end
               end
               StData: begin
                  if (tick_q) begin
                     if (bit_done) begin
                        hop_clk_q <= 1'b1;
                        cnt_q     <= '0;
                        if (idx_q == hop_last) begin
                           idx_q <= '0;
                           ph_q  <= sh_base_q;
                        end else begin
                           idx_q <= idx_q + HopOne;
                           ph_q  <= ph_q + sh_step_q;  // wraps modulo 2^PHASE_WIDTH
                        end
                        if (!last_bit) begin
                           bcnt_q   <= bcnt_next;
                           tx_bit_q <= sh_bits_q[bcnt_next];
                        end
                     end else begin
                        cnt_q <= cnt_q + NsOne;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
            // Frame end overrides the state chosen above.
            if (frame_end) begin
               frame_done_q <= 1'b1;
               tx_bit_q     <= 1'b0;
               if (cont_mode) begin
                  state_q <= StAlign;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign hop_ph_inc   = ph_q;
   assign hop_idx      = idx_q;
   assign hop_clk      = hop_clk_q;
   assign hop_rst      = hop_rst_q;
   assign tx_bit       = tx_bit_q;
   assign ntx_bits_cnt = bcnt_q;
   assign mtx_state    = state_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;

   always_comb begin
      fp_gpio_out              = '0;
      fp_gpio_out[TX_GPIO_BIT] = tx_bit_q;
      fp_gpio_ddr              = '0;
      fp_gpio_ddr[TX_GPIO_BIT] = 1'b1;
   end

endmodule

// File: tb/tb_mtx_tag_hop_ctrl.sv
// Directed bench for mtx_tag_hop_ctrl. The DCO pin is driven synchronously from the
// bench: each tick is 4 clk periods high then 4 low, so every output update from a
// tick has landed before the task returns.
module tb_mtx_tag_hop_ctrl;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          dco = 1'b0;
   logic [11:0]   gpio_in;
   logic          start = 1'b0, stop = 1'b0, cont_mode = 1'b0;
   logic [127:0]  tx_bits = '0;
   logic [6:0]    ntx_bits = '0;
   logic [15:0]   npilot = '0, edges_per_bit = '0;
   logic [3:0]    nhop = '0;
   logic [23:0]   hop_base_inc = '0, hop_step_inc = '0;
   logic [23:0]   hop_ph_inc;
   logic [3:0]    hop_idx;
   logic          hop_clk, hop_rst, tx_bit, busy, frame_done;
   logic [6:0]    ntx_bits_cnt;
   logic [1:0]    mtx_state;
   logic [11:0]   fp_gpio_out, fp_gpio_ddr;

   assign gpio_in = {10'h000, dco, 1'b0};

   always #5 clk = ~clk;

   mtx_tag_hop_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .fp_gpio_in   (gpio_in),
      .start        (start),
      .stop         (stop),
      .cont_mode    (cont_mode),
      .tx_bits      (tx_bits),
      .ntx_bits     (ntx_bits),
      .npilot       (npilot),
      .edges_per_bit(edges_per_bit),
      .nhop         (nhop),
      .hop_base_inc (hop_base_inc),
      .hop_step_inc (hop_step_inc),
      .hop_ph_inc   (hop_ph_inc),
      .hop_idx      (hop_idx),
      .hop_clk      (hop_clk),
      .hop_rst      (hop_rst),
      .tx_bit       (tx_bit),
      .ntx_bits_cnt (ntx_bits_cnt),
      .mtx_state    (mtx_state),
      .busy         (busy),
      .frame_done   (frame_done),
      .fp_gpio_out  (fp_gpio_out),
      .fp_gpio_ddr  (fp_gpio_ddr)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_hop_clk = 0, n_hop_rst = 0, n_done = 0, n_both = 0, n_idle = 0;

   always @(negedge clk) begin
      if (hop_clk) n_hop_clk <= n_hop_clk + 1;
      if (hop_rst) n_hop_rst <= n_hop_rst + 1;
      if (frame_done) n_done <= n_done + 1;
      if (hop_rst && frame_done) n_both <= n_both + 1;
      if (mtx_state == 2'd0) n_idle <= n_idle + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      dco = 1'b1;
      repeat (4) @(posedge clk);
      dco = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [15:0] np, input logic [6:0] nb, input logic [127:0] bits,
                          input logic [15:0] epb, input logic [3:0] nh,
                          input logic [23:0] base, input logic [23:0] step);
      npilot = np; ntx_bits = nb; tx_bits = bits; edges_per_bit = epb;
      nhop = nh; hop_base_inc = base; hop_step_inc = step;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_ph"}, 32'(hop_ph_inc), 32'h0);
      check_eq({tag, "_idx"}, 32'(hop_idx), 32'h0);
      check_eq({tag, "_tx"}, 32'(tx_bit), 32'h0);
      check_eq({tag, "_bcnt"}, 32'(ntx_bits_cnt), 32'h0);
      check_eq({tag, "_state"}, 32'(mtx_state), 32'h0);
      check_eq({tag, "_busy"}, 32'(busy), 32'h0);
      check_eq({tag, "_gpio"}, 32'(fp_gpio_out), 32'h0);
   endtask

   initial begin
      int c0, c1, c2, i0;
      logic [7:0]  a5;
      logic [23:0] wrap_exp [5];
      a5 = 8'hA5;
      wrap_exp = '{24'hFFFF00, 24'h000100, 24'h000300, 24'h000500, 24'hFFFF00};

      // Reset and idle
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      check_zero_outputs("rst");
      check_eq("rst_pulses", 32'({hop_clk, hop_rst, frame_done}), 32'h0);
      check_eq("ddr", 32'(fp_gpio_ddr), 32'h001);
      repeat (120) tick();
      check_zero_outputs("idle");
      check_eq("idle_hop_rst", 32'(n_hop_rst), 32'h0);

      // Single frame
      set_cfg(16'd4, 7'd8, 128'hA5, 16'd2, 4'd3, 24'd4096, 24'd512);
      c0 = n_hop_clk; c1 = n_done; c2 = n_hop_rst;
      do_start();
      check_eq("sf_align", 32'(mtx_state), 32'd1);
      check_eq("sf_busy", 32'(busy), 32'd1);
      tick();
      check_eq("sf_pilot", 32'(mtx_state), 32'd2);
      check_eq("sf_hop_rst", 32'(n_hop_rst - c2), 32'd1);
      check_eq("sf_ph0", 32'(hop_ph_inc), 32'd4096);
      check_eq("sf_tx_pilot", 32'(tx_bit), 32'd0);
      repeat (3) tick();
      check_eq("sf_pilot3", 32'(mtx_state), 32'd2);
      tick();
      check_eq("sf_data", 32'(mtx_state), 32'd3);
      check_eq("sf_gpio_out", 32'(fp_gpio_out), 32'h001);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("sf_tx%0d", i), 32'(tx_bit), 32'(a5[i]));
         check_eq($sformatf("sf_ph%0d", i), 32'(hop_ph_inc), 32'(4096 + 512 * (i % 3)));
         check_eq($sformatf("sf_idx%0d", i), 32'(hop_idx), 32'(i % 3));
         check_eq($sformatf("sf_bcnt%0d", i), 32'(ntx_bits_cnt), 32'(i));
         tick();
         check_eq($sformatf("sf_mid%0d", i), 32'(n_hop_clk - c0), 32'(i));
         tick();
      end
      check_eq("sf_hop_clks", 32'(n_hop_clk - c0), 32'd8);
      check_eq("sf_done", 32'(n_done - c1), 32'd1);
      check_eq("sf_idle", 32'(mtx_state), 32'd0);
      check_eq("sf_tx_end", 32'(tx_bit), 32'd0);

      // Phase wrap
      set_cfg(16'd0, 7'd5, 128'h0, 16'd1, 4'd4, 24'hFFFF00, 24'h000200);
      do_start();
      tick();
      check_eq("pw_data", 32'(mtx_state), 32'd3);
      check_eq("pw_ph0", 32'(hop_ph_inc), 32'(wrap_exp[0]));
      for (int i = 1; i < 5; i++) begin
         tick();
         check_eq($sformatf("pw_ph%0d", i), 32'(hop_ph_inc), 32'(wrap_exp[i]));
      end
      tick();
      check_eq("pw_idle", 32'(mtx_state), 32'd0);

      // Continuous mode
      cont_mode = 1'b1;
      set_cfg(16'd1, 7'd2, 128'h1, 16'd1, 4'd1, 24'd100, 24'd7);
      c1 = n_done; c2 = n_hop_rst;
      do_start();
      i0 = n_idle;
      tick();
      tx_bits = 128'h2;
      tick();
      check_eq("cm_f1_b0", 32'(tx_bit), 32'd1);
      tick();
      check_eq("cm_f1_b1", 32'(tx_bit), 32'd0);
      tick();
      check_eq("cm_done1", 32'(n_done - c1), 32'd1);
      check_eq("cm_realign", 32'(mtx_state), 32'd1);
      check_eq("cm_no_idle", 32'(n_idle - i0), 32'd0);
      cont_mode = 1'b0;
      tick();
      check_eq("cm_hop_rst2", 32'(n_hop_rst - c2), 32'd2);
      tick();
      check_eq("cm_f2_b0", 32'(tx_bit), 32'd0);
      tick();
      check_eq("cm_f2_b1", 32'(tx_bit), 32'd1);
      tick();
      check_eq("cm_done2", 32'(n_done - c1), 32'd2);
      check_eq("cm_idle", 32'(mtx_state), 32'd0);

      // Abort in DATA bit 3
      set_cfg(16'd4, 7'd8, 128'hA5, 16'd2, 4'd3, 24'd4096, 24'd512);
      do_start();
      repeat (5 + 6) tick();
      check_eq("ab_bit3", 32'(ntx_bits_cnt), 32'd3);
      c1 = n_done;
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      check_eq("ab_state", 32'(mtx_state), 32'd0);
      @(negedge clk); #1;
      check_zero_outputs("ab");
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check_eq("ab_no_done", 32'(n_done - c1), 32'd0);

      // Reset during PILOT with the pin high
      do_start();
      repeat (2) tick();
      check_eq("rp_pilot", 32'(mtx_state), 32'd2);
      dco = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      c2 = n_hop_rst; c1 = n_done;
      repeat (10) @(posedge clk);
      @(negedge clk); #1;
      check_zero_outputs("rp");
      // Degenerate npilot=0, ntx_bits=0; pin still high so no tick yet
      set_cfg(16'd0, 7'd0, 128'h0, 16'd1, 4'd1, 24'd55, 24'd1);
      do_start();
      repeat (10) @(posedge clk);
      @(negedge clk); #1;
      check_eq("rp_no_tick", 32'(mtx_state), 32'd1);
      check_eq("rp_no_hop_rst", 32'(n_hop_rst - c2), 32'd0);
      dco = 1'b0;
      repeat (4) @(posedge clk);
      c0 = n_both;
      tick();
      check_eq("dg_hop_rst", 32'(n_hop_rst - c2), 32'd1);
      check_eq("dg_done", 32'(n_done - c1), 32'd1);
      check_eq("dg_together", 32'(n_both - c0), 32'd1);
      check_eq("dg_idle", 32'(mtx_state), 32'd0);

      // edges_per_bit=0 and nhop=0
      set_cfg(16'd0, 7'd3, 128'h5, 16'd0, 4'd0, 24'd1234, 24'd99);
      c0 = n_hop_clk;
      do_start();
      tick();
      check_eq("e0_tx0", 32'(tx_bit), 32'd1);
      check_eq("e0_ph0", 32'(hop_ph_inc), 32'd1234);
      tick();
      check_eq("e0_tx1", 32'(tx_bit), 32'd0);
      check_eq("e0_ph1", 32'(hop_ph_inc), 32'd1234);
      check_eq("e0_idx1", 32'(hop_idx), 32'd0);
      check_eq("e0_hc1", 32'(n_hop_clk - c0), 32'd1);
      tick();
      check_eq("e0_tx2", 32'(tx_bit), 32'd1);
      check_eq("e0_ph2", 32'(hop_ph_inc), 32'd1234);
      check_eq("e0_hc2", 32'(n_hop_clk - c0), 32'd2);
      tick();
      check_eq("e0_hc3", 32'(n_hop_clk - c0), 32'd3);
      check_eq("e0_idle", 32'(mtx_state), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
